// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared state encodings and instruction bit indices for the PC sequencer
package pc_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_HALT  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam int OPC_BIT    = 15;
    localparam int JMP_LT_BIT = 2;
    localparam int JMP_EQ_BIT = 1;
    localparam int JMP_GT_BIT = 0;
    localparam int WAIT_W     = 8;

endpackage

// File: rtl/jump_cond.sv
// rtl/jump_cond.sv - combinational jump decision from the latched instruction and ALU flags
module jump_cond
    import pc_seq_pkg::*;
(
    input  logic [15:0] ir,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic        take
);

    // Only the opcode bit and the three jump bits matter here.
    logic w_unused_bits;
    assign w_unused_bits = ^ir[14:3];

    assign take = ir[OPC_BIT] &
                  ((ir[JMP_LT_BIT] & alu_ng) |
                   (ir[JMP_EQ_BIT] & alu_zr) |
                   (ir[JMP_GT_BIT] & ~alu_ng & ~alu_zr));

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/execute sequencer driving program-counter controls
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        halt_req,
    input  logic [15:0] instr,
    input  logic        imem_ready,
    input  logic        alu_zr,
    input  logic        alu_ng,
    input  logic [15:0] a_reg,
    output logic        imem_req,
    output logic [15:0] pc_in,
    output logic        pc_load,
    output logic        pc_inc,
    output logic        pc_reset,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic [2:0]  state
);

    localparam logic [WAIT_W-1:0] W_LIMIT = WAIT_W'(WAIT_LIMIT);

    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_wait;
    logic [15:0]       r_ir;
    logic              w_take;

    jump_cond u_jump_cond (
        .ir     (r_ir),
        .alu_zr (alu_zr),
        .alu_ng (alu_ng),
        .take   (w_take)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Wait counter restarts whenever FETCH is entered from any other state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ir   <= 16'h0000;
            r_wait <= '0;
        end else begin
            if (r_state == S_FETCH && imem_ready) begin
                r_ir <= instr;
            end
            if (w_next == S_FETCH && r_state != S_FETCH) begin
                r_wait <= '0;
            end else if (r_state == S_FETCH && !imem_ready) begin
                r_wait <= r_wait + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_FETCH;
            S_FETCH: begin
                if (imem_ready)             w_next = S_EXEC;
                else if (r_wait == W_LIMIT) w_next = S_FAULT;
            end
            S_EXEC:  w_next = halt_req ? S_HALT : S_FETCH;
            S_HALT:  if (start) w_next = S_FETCH;
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        ir_valid = 1'b0;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_in    = 16'h0000;
        if (reset) begin
            case (r_state)
                S_FETCH: imem_req = 1'b1;
                S_EXEC: begin
                    ir_valid = 1'b1;
                    pc_in    = a_reg;
                    pc_load  = w_take;
                    pc_inc   = ~w_take;
                end
                default: ;
            endcase
        end
    end

    assign pc_reset = ~reset;
    assign state    = reset ? r_state : S_IDLE;
    assign ir       = reset ? r_ir : 16'h0000;

endmodule
